serial_complement_unit: RTL and testbench

// - Multi-cycle negation/complement engine for the ALU datapath. It processes a WIDTH-bit operand LSB-first, DIGIT bits per cycle.
// - Two's complement uses the copy-through-first-1-then-invert rule; a flag register carries state between digits.
// - Supports negate, ones' complement, absolute value and pass modes.
// - Sits between the operand register file and the ALU result mux, with valid/ready handshakes on both sides.

---
 rtl/comp_pkg.sv | 17 +
 rtl/comp_digit.sv | 31 +++
 rtl/serial_complement_unit.sv | 148 ++++++++++++++
 tb/tb_serial_complement_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the serial complement unit.
//   mode_* : 2-bit operation codes presented on in_mode
//   state_t: control FSM encoding
package comp_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_INV  = 2'b10;
   localparam logic [1:0] MODE_ABS  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/comp_digit.sv
// One DIGIT-bit slice of the serial complement datapath (purely combinational).
//   op       : operand digit, bit 0 is the least significant
//   flag_in  : "a 1 has already been seen" from the lower digits
//   neg      : apply copy-through-first-1-then-invert (two's complement)
//   inv      : invert every bit (ones' complement); ignored when neg is set
//   res      : result digit
//   flag_out : flag carried into the next digit
module comp_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] op,
   input  logic             flag_in,
   input  logic             neg,
   input  logic             inv,
   output logic [DIGIT-1:0] res,
   output logic             flag_out
);

   // chain[b] is the flag as seen by bit b: set once any lower bit was 1
   logic [DIGIT:0] chain;

   assign chain[0] = flag_in;

   for (genvar b = 0; b < DIGIT; b++) begin : g_bit
      assign chain[b+1] = chain[b] | op[b];
      assign res[b]     = neg ? (op[b] ^ chain[b]) : (op[b] ^ inv);
   end

   assign flag_out = chain[DIGIT];

endmodule

// File: rtl/serial_complement_unit.sv
// Multi-cycle negate / ones' complement / absolute value / pass engine.
// The operand is consumed LSB-first, DIGIT bits per RUN cycle, through a
// single comp_digit slice; the result is assembled in a right-shifting
// register so that it lands correctly aligned after WIDTH/DIGIT cycles.
//
// Optional feature macro: COMP_FLAGS_EN adds the out_ovf / out_zero ports.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid / in_ready    operand handshake; in_ready high only in IDLE
//   in_mode                00 PASS, 01 NEG, 10 INV, 11 ABS
//   in_operand             operand
//   out_valid / out_ready  result handshake; out_valid held until accepted
//   out_result             result
//   out_ovf, out_zero      signed overflow / zero result (COMP_FLAGS_EN)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an operand, in_ready = 1
// ST_RUN  | one digit per cycle, WIDTH/DIGIT cycles
// ST_DONE | first cycle raises out_valid, then waits for out_ready
module serial_complement_unit
   import comp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [WIDTH-1:0] in_operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result
`ifdef COMP_FLAGS_EN
   ,
   output logic             out_ovf,
   output logic             out_zero
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
      $error("serial_complement_unit: DIGIT must be in 1..WIDTH");
   end else if (WIDTH % DIGIT != 0) begin : g_bad_ratio
      $error("serial_complement_unit: WIDTH must be a multiple of DIGIT");
   end

   state_t           state;
   logic [WIDTH-1:0] op_sr;
   logic [WIDTH-1:0] res_sr;
   logic [CW-1:0]    cnt;
   logic             flag;
   logic             eff_neg;
   logic             eff_inv;
   logic [DIGIT-1:0] dig_res;
   logic             dig_flag;
`ifdef COMP_FLAGS_EN
   logic             sign;
`endif

   comp_digit #(.DIGIT(DIGIT)) u_digit (
      .op       (op_sr[DIGIT-1:0]),
      .flag_in  (flag),
      .neg      (eff_neg),
      .inv      (eff_inv),
      .res      (dig_res),
      .flag_out (dig_flag)
   );

   assign out_result = res_sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         op_sr     <= '0;
         res_sr    <= '0;
         cnt       <= '0;
         flag      <= 1'b0;
         eff_neg   <= 1'b0;
         eff_inv   <= 1'b0;
`ifdef COMP_FLAGS_EN
         sign      <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  // ABS is resolved to NEG or PASS here from the latched sign
                  op_sr    <= in_operand;
                  eff_neg  <= (in_mode == MODE_NEG) ||
                              ((in_mode == MODE_ABS) && in_operand[WIDTH-1]);
                  eff_inv  <= (in_mode == MODE_INV);
                  flag     <= 1'b0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= ST_RUN;
`ifdef COMP_FLAGS_EN
                  sign     <= in_operand[WIDTH-1];
                  out_ovf  <= 1'b0;
                  out_zero <= 1'b1;
`endif
               end
            end
            ST_RUN: begin
               op_sr  <= op_sr >> DIGIT;
               res_sr <= (res_sr >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
               flag   <= dig_flag;
               cnt    <= cnt + 1'b1;
`ifdef COMP_FLAGS_EN
               out_zero <= out_zero & ~(|dig_res);
`endif
               if (cnt == CNT_LAST) begin
                  state <= ST_DONE;
`ifdef COMP_FLAGS_EN
                  // only the most-negative operand stays negative after NEG
                  out_ovf <= eff_neg & sign & dig_res[DIGIT-1];
`endif
               end
            end
            ST_DONE: begin
               if (!out_valid) begin
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_complement_unit.sv
// Directed bench for serial_complement_unit. Instance 0 uses DIGIT=4; the
// other three (DIGIT 1, 8, 32) cover the digit-width sweep against a golden
// model. Flag checks are compiled in when COMP_FLAGS_EN is defined.
module tb_serial_complement_unit;

   localparam int NU = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        u_in_valid  [NU];
   logic        u_in_ready  [NU];
   logic [1:0]  u_mode      [NU];
   logic [31:0] u_op        [NU];
   logic        u_out_valid [NU];
   logic        u_out_ready [NU];
   logic [31:0] u_res       [NU];
`ifdef COMP_FLAGS_EN
   logic        u_ovf       [NU];
   logic        u_zero      [NU];
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NU; g++) begin : g_dut
      serial_complement_unit #(
         .WIDTH (32),
         .DIGIT ((g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (u_in_valid[g]),
         .in_ready   (u_in_ready[g]),
         .in_mode    (u_mode[g]),
         .in_operand (u_op[g]),
         .out_valid  (u_out_valid[g]),
         .out_ready  (u_out_ready[g]),
         .out_result (u_res[g])
`ifdef COMP_FLAGS_EN
         ,
         .out_ovf    (u_ovf[g]),
         .out_zero   (u_zero[g])
`endif
      );
   end

   function automatic int dig(input int g);
      return (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
   endfunction

   function automatic logic [31:0] gold(input logic [1:0] m, input logic [31:0] x);
      case (m)
         2'b00:   return x;
         2'b01:   return -x;
         2'b10:   return ~x;
         default: return x[31] ? -x : x;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one operand and return just after the accept edge; the inputs
   // are then scrambled so that a design not latching them would be caught.
   task automatic start(input int g, input logic [1:0] m, input logic [31:0] x);
      int t;
      t = 0;
      while (!u_in_ready[g] && t < 200) begin
         @(posedge clk); #1; t++;
      end
      chk("in_ready_before_accept", 32'(u_in_ready[g]), 32'd1);
      u_mode[g]     = m;
      u_op[g]       = x;
      u_in_valid[g] = 1'b1;
      @(posedge clk); #1;
      u_in_valid[g] = 1'b0;
      u_mode[g]     = ~m;
      u_op[g]       = ~x;
   endtask

   task automatic wait_done(input int g, output int lat);
      lat = 0;
      while (!u_out_valid[g] && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic release_out(input int g);
      u_out_ready[g] = 1'b1;
      @(posedge clk); #1;
      u_out_ready[g] = 1'b0;
      chk("out_valid_after_accept", 32'(u_out_valid[g]), 32'd0);
      chk("in_ready_after_accept", 32'(u_in_ready[g]), 32'd1);
   endtask

   task automatic run_op(input int g, input logic [1:0] m, input logic [31:0] x,
                         input logic [31:0] exp, input string tag);
      int lat;
      start(g, m, x);
      wait_done(g, lat);
      chk({tag, "_latency"}, 32'(lat), 32'(32 / dig(g) + 1));
      chk(tag, u_res[g], exp);
`ifdef COMP_FLAGS_EN
      chk({tag, "_ovf"}, 32'(u_ovf[g]),
          32'((m == 2'b01 || (m == 2'b11 && x[31])) && x[31] && exp[31]));
      chk({tag, "_zero"}, 32'(u_zero[g]), 32'(exp == 32'd0));
`endif
      release_out(g);
   endtask

   initial begin : stim
      int  lat;
      bit  saw_valid;
      logic [31:0] x;
      logic [1:0]  m;

      rst_n = 1'b0;
      for (int g = 0; g < NU; g++) begin
         u_in_valid[g]  = 1'b0;
         u_mode[g]      = 2'b00;
         u_op[g]        = 32'd0;
         u_out_ready[g] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 32'(u_in_ready[0]), 32'd1);
      chk("reset_out_valid", 32'(u_out_valid[0]), 32'd0);
      chk("reset_out_result", u_res[0], 32'd0);
`ifdef COMP_FLAGS_EN
      chk("reset_ovf", 32'(u_ovf[0]), 32'd0);
      chk("reset_zero", 32'(u_zero[0]), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed vectors on the DIGIT=4 instance
      run_op(0, 2'b01, 32'h0000_0001, 32'hFFFF_FFFF, "neg_one");
      run_op(0, 2'b01, 32'h8000_0000, 32'h8000_0000, "neg_min");
      run_op(0, 2'b01, 32'h0000_0000, 32'h0000_0000, "neg_zero");
      run_op(0, 2'b11, 32'hFFFF_FFF6, 32'h0000_000A, "abs_neg");
      run_op(0, 2'b11, 32'h0000_002A, 32'h0000_002A, "abs_pos");
      run_op(0, 2'b10, 32'h0F0F_0F0F, 32'hF0F0_F0F0, "inv");
      run_op(0, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "pass");
      run_op(0, 2'b01, 32'h0001_0000, 32'hFFFF_0000, "neg_mid_one");

      // backpressure: DONE held with in_valid asserted, then back-to-back op
      start(0, 2'b10, 32'h0F0F_0F0F);
      wait_done(0, lat);
      chk("bp_latency", 32'(lat), 32'd9);
      u_mode[0]     = 2'b01;
      u_op[0]       = 32'h0000_0003;
      u_in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid_held", 32'(u_out_valid[0]), 32'd1);
         chk("bp_result_held", u_res[0], 32'hF0F0_F0F0);
         chk("bp_in_ready_low", 32'(u_in_ready[0]), 32'd0);
      end
      u_out_ready[0] = 1'b1;
      @(posedge clk); #1;
      u_out_ready[0] = 1'b0;
      chk("bp_release_out_valid", 32'(u_out_valid[0]), 32'd0);
      chk("bp_release_in_ready", 32'(u_in_ready[0]), 32'd1);
      @(posedge clk); #1;
      u_in_valid[0] = 1'b0;
      chk("b2b_accepted", 32'(u_in_ready[0]), 32'd0);
      wait_done(0, lat);
      chk("b2b_latency", 32'(lat), 32'd9);
      chk("b2b_result", u_res[0], 32'hFFFF_FFFD);
      release_out(0);

      // reset after three digits of a NEG
      start(0, 2'b01, 32'h1234_5678);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_out_valid", 32'(u_out_valid[0]), 32'd0);
      chk("midrun_rst_in_ready", 32'(u_in_ready[0]), 32'd1);
      chk("midrun_rst_result", u_res[0], 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (u_out_valid[0]) saw_valid = 1'b1;
      end
      chk("midrun_rst_no_valid", 32'(saw_valid), 32'd0);
      run_op(0, 2'b01, 32'h0000_0005, 32'hFFFF_FFFB, "post_rst_neg5");

      // digit-width sweep: every mode on each instance, random plus corners
      for (int g = 1; g < NU; g++) begin
         for (int i = 0; i < 10; i++) begin
            m = 2'(i % 4);
            x = (i == 8) ? 32'h8000_0000 : (i == 9) ? 32'h0000_0000 : $urandom;
            run_op(g, m, x, gold(m, x), $sformatf("sweep_d%0d_m%0d", dig(g), m));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
